// File: rtl/fft_frame_writer_if.sv
// FFT source stream carrying one 4-channel beat per bin.
// The FFT source drives the stream through the master modport.
// The frame writer receives it through the slave modport.
interface fft_frame_writer_if #(
  parameter int DW = 14
);
  logic            sink_valid;
  logic            sink_sop;
  logic            sink_eop;
  logic [8*DW-1:0] sink_data;
  logic            sink_ready;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_data,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_data,
    output sink_ready
  );
endinterface

// File: rtl/fft_frame_writer.sv
// fft_frame_writer: captures one 4-channel FFT frame into the channel RAMs.
// It also tracks the peak-power bin of channel 1 over bins MINBIN..NPTS/2-1.
// The frame is then handed to the weight block with a detectdone/weightdone
// handshake.
// Optional feature macro THRESH_EN: adds pwr_thresh. When it is defined, a
// frame whose peak power is below the threshold is dropped without raising
// detectdone.
module fft_frame_writer #(
  parameter int NPTS   = 1024,
  parameter int AW     = 10,
  parameter int DW     = 14,
  parameter int MINBIN = 1
) (
  input  logic              clk,
  input  logic              reset,
  fft_frame_writer_if.slave sink,
  output logic              wren,
  output logic [AW-1:0]     wraddr,
  output logic [2*DW-1:0]   wrdata1,
  output logic [2*DW-1:0]   wrdata2,
  output logic [2*DW-1:0]   wrdata3,
  output logic [2*DW-1:0]   wrdata4,
  output logic [AW-1:0]     rdaddr1,
  output logic [AW-1:0]     maxbin,
  output logic              detectdone,
  input  logic              weightdone
`ifdef THRESH_EN
  ,
  input  logic [2*DW-1:0]   pwr_thresh
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] ZERO_BIN = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_BIN  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_BIN = AW'(NPTS - 1);
  localparam logic [AW-1:0] LO_BIN   = AW'(MINBIN);
  localparam logic [AW-1:0] HI_BIN   = AW'(NPTS / 2 - 1);

  state_t            state;
  logic [AW-1:0]     bin;
  logic              flush_cnt;
  logic              take;
  logic [2*DW-1:0]   re_x;
  logic [2*DW-1:0]   im_x;
  logic [2*DW-1:0]   pwr_now;
  logic              p1_valid;
  logic              p1_sop;
  logic [AW-1:0]     p1_bin;
  logic [2*DW-1:0]   p1_pwr;
  logic [2*DW-1:0]   maxpwr;
  logic [AW-1:0]     cand_bin;

  // A beat is taken when accepted as a frame start in IDLE or as any beat in FILL
  assign take = sink.sink_valid & sink.sink_ready &
                (((state == IDLE) & sink.sink_sop) | (state == FILL));

  // Channel 1 power. The sign-extended squares are exact modulo 2^(2*DW).
  // The sum is below 2^(2*DW), so it is exact as well.
  assign re_x    = {{DW{sink.sink_data[2*DW-1]}}, sink.sink_data[2*DW-1:DW]};
  assign im_x    = {{DW{sink.sink_data[DW-1]}},   sink.sink_data[DW-1:0]};
  assign pwr_now = re_x * re_x + im_x * im_x;

  // Frame FSM with the RAM write port, ready and handshake outputs all registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      bin             <= ZERO_BIN;
      flush_cnt       <= 1'b0;
      sink.sink_ready <= 1'b0;
      wren            <= 1'b0;
      wraddr          <= ZERO_BIN;
      wrdata1         <= '0;
      wrdata2         <= '0;
      wrdata3         <= '0;
      wrdata4         <= '0;
      rdaddr1         <= ZERO_BIN;
      maxbin          <= ZERO_BIN;
      detectdone      <= 1'b0;
    end else begin
      wren <= take;
      if (take) begin
        wraddr  <= sink.sink_sop ? ZERO_BIN : bin;
        wrdata1 <= sink.sink_data[2*DW-1:0];
        wrdata2 <= sink.sink_data[4*DW-1:2*DW];
        wrdata3 <= sink.sink_data[6*DW-1:4*DW];
        wrdata4 <= sink.sink_data[8*DW-1:6*DW];
      end
      case (state)
        IDLE: begin
          sink.sink_ready <= 1'b1;
          detectdone      <= 1'b0;
          if (take) begin
            state <= FILL;
            bin   <= ONE_BIN;
          end
        end
        FILL: begin
          if (take) begin
            if (sink.sink_sop) begin
              bin <= ONE_BIN;            // restart: this beat is the new bin 0
            end else if (bin == LAST_BIN) begin
              state           <= FLUSH;  // last bin closes the frame, eop or not
              flush_cnt       <= 1'b0;
              sink.sink_ready <= 1'b0;
            end else if (sink.sink_eop) begin
              state <= IDLE;             // short frame is discarded
            end else begin
              bin <= bin + ONE_BIN;
            end
          end
        end
        FLUSH: begin
          if (!flush_cnt) begin
            flush_cnt <= 1'b1;
          end else begin
            flush_cnt <= 1'b0;
`ifdef THRESH_EN
            if (maxpwr < pwr_thresh) begin
              state           <= IDLE;
              sink.sink_ready <= 1'b1;
            end else
`endif
            begin
              state      <= DONE;
              detectdone <= 1'b1;
              maxbin     <= cand_bin;
              rdaddr1    <= cand_bin;
            end
          end
        end
        DONE: begin
          if (weightdone) begin
            state           <= IDLE;
            detectdone      <= 1'b0;
            rdaddr1         <= ZERO_BIN;
            sink.sink_ready <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          sink.sink_ready <= 1'b0;
          detectdone      <= 1'b0;
          rdaddr1         <= ZERO_BIN;
        end
      endcase
    end
  end

  // Two-stage peak search: register the power, then compare strictly so ties keep the lowest bin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_valid <= 1'b0;
      p1_sop   <= 1'b0;
      p1_bin   <= ZERO_BIN;
      p1_pwr   <= '0;
      maxpwr   <= '0;
      cand_bin <= ZERO_BIN;
    end else begin
      p1_valid <= take;
      if (take) begin
        p1_sop <= sink.sink_sop;
        p1_bin <= sink.sink_sop ? ZERO_BIN : bin;
        p1_pwr <= pwr_now;
      end
      if (p1_valid) begin
        if (p1_sop) begin
          maxpwr   <= '0;
          cand_bin <= ZERO_BIN;
        end else if ((p1_bin >= LO_BIN) && (p1_bin <= HI_BIN) && (p1_pwr > maxpwr)) begin
          maxpwr   <= p1_pwr;
          cand_bin <= p1_bin;
        end
      end
    end
  end

endmodule
